fmap_idx_gen: RTL and testbench

Feature-map index generator for the Animation-ResNet datapath, and the producer side of the layer sequencer's status inputs. From the sequencer's 4-bit layer state it zero-fills the padding buffer and raises `pad_end`. It then issues per-tile requests to the PE array and counts completed feature maps. It drives `fmap_idx` plus a 4-cycle-delayed copy, so the sequencer sees the terminal index for exactly one cycle per layer.

---
 rtl/resnet_pkg.sv | 52 +++++
 rtl/idx_delay_line.sv | 29 ++
 rtl/fmap_idx_gen.sv | 189 ++++++++++++++++++
 tb/tb_fmap_idx_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/resnet_pkg.sv
// Shared definitions for the Animation-ResNet layer sequencer and its
// producers: layer state encodings, per-layer feature-map counts, the
// generator's internal FSM encoding and the fmap index delay depth.
package resnet_pkg;

    // Layer state as driven by the sequencer on its 4-bit state bus
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        PADDING = 4'd1,
        CONV1   = 4'd2,
        RES_1   = 4'd3,
        RES_2   = 4'd4,
        UP_1    = 4'd5,
        UP_2    = 4'd6,
        CONV2   = 4'd7,
        FINISH  = 4'd8
    } layer_e;

    // Index generator FSM states
    typedef enum logic [2:0] {
        G_IDLE    = 3'd0,
        G_PAD     = 3'd1,
        G_PADWAIT = 3'd2,
        G_REQ     = 3'd3,
        G_BUSY    = 3'd4,
        G_TERM    = 3'd5,
        G_HOLD    = 3'd6,
        G_DONE    = 3'd7
    } gen_state_e;

    localparam int unsigned FMAPS_MAIN      = 24;  // CONV1, RES_1, RES_2
    localparam int unsigned FMAPS_UP        = 96;  // UP_1, UP_2
    localparam int unsigned FMAPS_OUT       = 3;   // CONV2
    localparam int unsigned IDX_DELAY_DEPTH = 4;

    // Feature maps produced by a layer; non-compute codes count as one so
    // the terminal compare never underflows.
    function automatic int unsigned layer_fmaps(input logic [3:0] layer);
        case (layer)
            CONV1, RES_1, RES_2: return FMAPS_MAIN;
            UP_1, UP_2:          return FMAPS_UP;
            CONV2:               return FMAPS_OUT;
            default:             return 1;
        endcase
    endfunction

    // Codes above FINISH are undefined on the state bus
    function automatic logic layer_known(input logic [3:0] layer);
        return (layer <= 4'(FINISH));
    endfunction

endpackage

// File: rtl/idx_delay_line.sv
// Fixed-depth shift chain for the fmap index.
// Ports: i_clk clock; i_rst synchronous active-high clear of every stage;
//        i_d index in; o_q index from DEPTH cycles earlier.
module idx_delay_line #(
    parameter int unsigned W     = 7,
    parameter int unsigned DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    localparam int unsigned CHAIN_W = W * DEPTH;

    logic [CHAIN_W-1:0] r_chain;

    // Newest sample enters at the bottom, oldest leaves at the top
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[CHAIN_W-W-1:0], i_d};
        end
    end

    assign o_q = r_chain[CHAIN_W-1 -: W];

endmodule

// File: rtl/fmap_idx_gen.sv
// Feature-map index generator: zero-fills the padding buffer, then walks
// every tile of every feature map of each layer, handshaking with the PE
// array, and publishes the fmap index plus a 4-cycle-delayed copy that the
// sequencer uses to detect layer completion.
// Ports: i_clk/i_rst clock and synchronous active-high reset;
//        i_state sequencer layer state; i_tile_done PE tile completion pulse;
//        o_tile_req tile start pulse; o_tile_idx current tile;
//        o_pad_we/o_pad_addr/o_pad_end padding buffer fill;
//        o_fmap_idx current fmap (N for one terminal cycle);
//        o_fmap_idx_delay4 o_fmap_idx delayed by four cycles.
module fmap_idx_gen
    import resnet_pkg::*;
#(
    parameter int unsigned PAD_WORDS      = 1024,
    parameter int unsigned TILES_PER_FMAP = 16,
    parameter int unsigned IDX_W          = 7,
    localparam int unsigned PAD_AW = (PAD_WORDS > 1) ? $clog2(PAD_WORDS) : 1,
    localparam int unsigned TILE_W = (TILES_PER_FMAP > 1) ? $clog2(TILES_PER_FMAP) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_state,
    input  logic              i_tile_done,
    output logic              o_tile_req,
    output logic [TILE_W-1:0] o_tile_idx,
    output logic              o_pad_we,
    output logic [PAD_AW-1:0] o_pad_addr,
    output logic              o_pad_end,
    output logic [IDX_W-1:0]  o_fmap_idx,
    output logic [IDX_W-1:0]  o_fmap_idx_delay4
);

    localparam logic [PAD_AW-1:0] PAD_LAST  = PAD_AW'(PAD_WORDS - 1);
    localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(TILES_PER_FMAP - 1);

    gen_state_e        r_gstate,   w_gstate_nx;
    logic [3:0]        r_layer,    w_layer_nx;
    logic [TILE_W-1:0] r_tile,     w_tile_nx;
    logic [IDX_W-1:0]  r_fmap,     w_fmap_nx;
    logic [PAD_AW-1:0] r_pad_addr, w_pad_addr_nx;
    logic              r_pad_we,   w_pad_we_nx;
    logic              r_pad_end,  w_pad_end_nx;
    logic              r_tile_req, w_tile_req_nx;
    logic              r_adv,      w_adv_nx;
    logic [IDX_W-1:0]  w_n;

    assign w_n = IDX_W'(layer_fmaps(r_layer));

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gstate   <= G_IDLE;
            r_layer    <= 4'(IDLE);
            r_tile     <= '0;
            r_fmap     <= '0;
            r_pad_addr <= '0;
            r_pad_we   <= 1'b0;
            r_pad_end  <= 1'b0;
            r_tile_req <= 1'b0;
            r_adv      <= 1'b0;
        end else begin
            r_gstate   <= w_gstate_nx;
            r_layer    <= w_layer_nx;
            r_tile     <= w_tile_nx;
            r_fmap     <= w_fmap_nx;
            r_pad_addr <= w_pad_addr_nx;
            r_pad_we   <= w_pad_we_nx;
            r_pad_end  <= w_pad_end_nx;
            r_tile_req <= w_tile_req_nx;
            r_adv      <= w_adv_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_gstate_nx   = r_gstate;
        w_layer_nx    = r_layer;
        w_tile_nx     = r_tile;
        w_fmap_nx     = r_fmap;
        w_pad_addr_nx = r_pad_addr;
        w_pad_we_nx   = 1'b0;
        w_pad_end_nx  = 1'b0;
        w_tile_req_nx = 1'b0;
        w_adv_nx      = 1'b0;

        case (r_gstate)
            G_IDLE: begin
                if (i_state == PADDING) begin
                    w_gstate_nx   = G_PAD;
                    w_pad_we_nx   = 1'b1;
                    w_pad_addr_nx = '0;
                end
            end

            G_PAD: begin
                if (r_pad_addr == PAD_LAST) begin
                    w_pad_end_nx  = 1'b1;
                    w_pad_addr_nx = '0;
                    w_gstate_nx   = G_PADWAIT;
                end else begin
                    w_pad_we_nx   = 1'b1;
                    w_pad_addr_nx = r_pad_addr + PAD_AW'(1);
                end
            end

            G_PADWAIT: begin
                if (i_state == CONV1) begin
                    w_layer_nx    = i_state;
                    w_tile_nx     = '0;
                    w_fmap_nx     = '0;
                    w_tile_req_nx = 1'b1;
                    w_gstate_nx   = G_REQ;
                end
            end

            // tile_req is high for exactly this cycle; tile_done is dropped
            G_REQ: begin
                w_gstate_nx = G_BUSY;
            end

            // r_adv marks the cycle after counter update, before the next request
            G_BUSY: begin
                if (r_adv) begin
                    w_tile_req_nx = 1'b1;
                    w_gstate_nx   = G_REQ;
                end else if (i_tile_done) begin
                    if (r_tile != TILE_LAST) begin
                        w_tile_nx = r_tile + TILE_W'(1);
                        w_adv_nx  = 1'b1;
                    end else if (r_fmap != (w_n - IDX_W'(1))) begin
                        w_tile_nx = '0;
                        w_fmap_nx = r_fmap + IDX_W'(1);
                        w_adv_nx  = 1'b1;
                    end else begin
                        w_fmap_nx   = w_n;
                        w_gstate_nx = G_TERM;
                    end
                end
            end

            G_TERM: begin
                w_fmap_nx   = '0;
                w_tile_nx   = '0;
                w_gstate_nx = G_HOLD;
            end

            // Wait for the sequencer to move on; undefined codes are ignored
            G_HOLD: begin
                if ((i_state != r_layer) && layer_known(i_state)) begin
                    if (i_state == FINISH) begin
                        w_gstate_nx = G_DONE;
                    end else begin
                        w_layer_nx    = i_state;
                        w_tile_nx     = '0;
                        w_fmap_nx     = '0;
                        w_tile_req_nx = 1'b1;
                        w_gstate_nx   = G_REQ;
                    end
                end
            end

            G_DONE: begin
                w_gstate_nx = G_DONE;
            end

            default: begin
                w_gstate_nx = G_IDLE;
            end
        endcase
    end

    idx_delay_line #(
        .W     (IDX_W),
        .DEPTH (IDX_DELAY_DEPTH)
    ) u_delay (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (r_fmap),
        .o_q   (o_fmap_idx_delay4)
    );

    assign o_tile_req = r_tile_req;
    assign o_tile_idx = r_tile;
    assign o_pad_we   = r_pad_we;
    assign o_pad_addr = r_pad_addr;
    assign o_pad_end  = r_pad_end;
    assign o_fmap_idx = r_fmap;

endmodule

// File: tb/tb_fmap_idx_gen.sv
// Directed bench for fmap_idx_gen with a small PE-array responder.
module tb_fmap_idx_gen;
    import resnet_pkg::*;

    localparam int unsigned PW  = 8;
    localparam int unsigned TPF = 2;
    localparam int unsigned IW  = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] st;
    logic       tile_done;
    logic       tile_req;
    logic [0:0] tile_idx;
    logic       pad_we;
    logic [2:0] pad_addr;
    logic       pad_end;
    logic [6:0] fmap_idx;
    logic [6:0] fmap_d4;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] state;
        logic       td;
        logic       exp_we;
        int         exp_addr;
        logic       exp_end;
        logic       exp_req;
        int         exp_fmap;
    } vec_t;

    vec_t pad_vecs[12];

    always #5 clk = ~clk;

    fmap_idx_gen #(
        .PAD_WORDS      (PW),
        .TILES_PER_FMAP (TPF),
        .IDX_W          (IW)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_state           (st),
        .i_tile_done       (tile_done),
        .o_tile_req        (tile_req),
        .o_tile_idx        (tile_idx),
        .o_pad_we          (pad_we),
        .o_pad_addr        (pad_addr),
        .o_pad_end         (pad_end),
        .o_fmap_idx        (fmap_idx),
        .o_fmap_idx_delay4 (fmap_d4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_req"},   int'(tile_req), 0);
        chk({nm, "_tile"},  int'(tile_idx), 0);
        chk({nm, "_we"},    int'(pad_we),   0);
        chk({nm, "_addr"},  int'(pad_addr), 0);
        chk({nm, "_end"},   int'(pad_end),  0);
        chk({nm, "_fmap"},  int'(fmap_idx), 0);
        chk({nm, "_d4"},    int'(fmap_d4),  0);
    endtask

    task automatic run_pad_table();
        for (int i = 0; i < 12; i++) begin
            st        = pad_vecs[i].state;
            tile_done = pad_vecs[i].td;
            tick();
            tile_done = 1'b0;
            chk($sformatf("pad%0d_we", i),   int'(pad_we),   int'(pad_vecs[i].exp_we));
            chk($sformatf("pad%0d_addr", i), int'(pad_addr), pad_vecs[i].exp_addr);
            chk($sformatf("pad%0d_end", i),  int'(pad_end),  int'(pad_vecs[i].exp_end));
            chk($sformatf("pad%0d_req", i),  int'(tile_req), int'(pad_vecs[i].exp_req));
            chk($sformatf("pad%0d_fmap", i), int'(fmap_idx), pad_vecs[i].exp_fmap);
        end
    endtask

    task automatic wait_req();
        bit found = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (tile_req === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("req_seen", int'(found), 1);
    endtask

    // Request cycle c; optional spurious done during c; real done in c+3
    task automatic serve_tile(input int f, input int t, input bit spur, input bit respond);
        wait_req();
        chk($sformatf("req_fmap_f%0d_t%0d", f, t), int'(fmap_idx), f);
        chk($sformatf("req_tile_f%0d_t%0d", f, t), int'(tile_idx), t);
        if (spur) tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
        chk("req_one_cycle", int'(tile_req), 0);
        if (respond) begin
            tick();
            tick();
            tile_done = 1'b1;
            tick();
            tile_done = 1'b0;
        end
    endtask

    task automatic run_layer(input int n, input bit spur);
        for (int f = 0; f < n; f++)
            for (int t = 0; t < int'(TPF); t++)
                serve_tile(f, t, spur, 1'b1);
    endtask

    // Terminal cycle T through T+5, with a stray done in G_HOLD at T+2
    task automatic finish_layer(input int n);
        bit found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (int'(fmap_idx) == n) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("term_seen", int'(found), 1);
        tick();
        chk("term_t1_fmap", int'(fmap_idx), 0);
        chk("term_t1_req",  int'(tile_req), 0);
        tick();
        tile_done = 1'b1;
        chk("term_t2_fmap", int'(fmap_idx), 0);
        tick();
        tile_done = 1'b0;
        chk("term_t3_d4",   int'(fmap_d4),  n - 1);
        chk("term_t3_req",  int'(tile_req), 0);
        tick();
        chk("term_t4_d4",   int'(fmap_d4),  n);
        chk("term_t4_req",  int'(tile_req), 0);
        tick();
        chk("term_t5_d4",   int'(fmap_d4),  0);
        chk("term_t5_req",  int'(tile_req), 0);
        chk("term_t5_fmap", int'(fmap_idx), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 8; k++)
            pad_vecs[k] = '{PADDING, 1'b0, 1'b1, k, 1'b0, 1'b0, 0};
        pad_vecs[8]  = '{PADDING, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0};
        pad_vecs[9]  = '{PADDING, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
        pad_vecs[10] = '{IDLE,    1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
        pad_vecs[11] = '{4'hF,    1'b1, 1'b0, 0, 1'b0, 1'b0, 0};

        rst       = 1'b1;
        st        = IDLE;
        tile_done = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk("idle_we", int'(pad_we), 0);

        run_pad_table();

        st = CONV1;
        run_layer(24, 1'b0);
        finish_layer(24);

        st = RES_1;
        run_layer(24, 1'b0);
        finish_layer(24);

        st = CONV2;
        run_layer(3, 1'b1);
        finish_layer(3);

        st = FINISH;
        for (int k = 0; k < 12; k++) begin
            if ((k % 3) == 1) tile_done = 1'b1;
            tick();
            tile_done = 1'b0;
            chk("done_req",  int'(tile_req), 0);
            chk("done_fmap", int'(fmap_idx), 0);
        end

        rst = 1'b1;
        st  = IDLE;
        tick();
        rst = 1'b0;
        tick();
        run_pad_table();
        st = CONV1;
        run_layer(24, 1'b0);
        finish_layer(24);

        st = UP_1;
        for (int f = 0; f < 10; f++)
            for (int t = 0; t < int'(TPF); t++)
                serve_tile(f, t, 1'b0, 1'b1);
        wait_req();
        chk("up1_f10_fmap", int'(fmap_idx), 10);
        chk("up1_f10_tile", int'(tile_idx), 0);
        rst = 1'b1;
        st  = IDLE;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_d4",   int'(fmap_d4),  0);
            chk("post_rst_fmap", int'(fmap_idx), 0);
            chk("post_rst_we",   int'(pad_we),   0);
        end
        st = PADDING;
        tick();
        chk("restart_we",   int'(pad_we),   1);
        chk("restart_addr", int'(pad_addr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
